// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a byte-enabled synchronous data RAM.
// Optional `MEM_STAGE_MISALIGN_TRAP_EN blocks misaligned accesses.
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [4:0]  WriteReg,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic        Stall,
    output logic        OutValid,
    output logic [31:0] ReadData,
    output logic [31:0] OutAluResult,
    output logic [4:0]  OutWriteReg,
    output logic        OutRegWrite,
    output logic        OutMemtoReg,
    output logic        Misaligned
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        mis_q, mis_d;

    // load context captured at the accepting edge
    logic [31:0] ld_addr_q;
    logic [1:0]  ld_size_q;
    logic        ld_sgn_q;
    logic [4:0]  ld_wreg_q;
    logic        ld_rw_q;
    logic        ld_m2r_q;
    logic        ld_mis_q;
    logic [31:0] rdata_q;

    logic          is_load;
    logic          is_store;
    logic          mis;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [AW-1:0] idx;

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic        sg,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'b00:   return {{24{sg & b[7]}}, b};
            2'b01:   return {{16{sg & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // request decode, lane enables and store data replication
    always_comb begin
        is_load  = (state_q == IDLE) && InValid && MemRead && !MemWrite;
        is_store = (state_q == IDLE) && InValid && MemWrite;
        mis      = (MemRead || MemWrite) &&
                   ((MemSize == 2'b01 && Address[0]) ||
                    (MemSize[1] && Address[1:0] != 2'b00));
        idx      = Address[AW+1:2];
        unique case (MemSize)
            2'b00: begin
                be        = 4'b0001 << Address[1:0];
                wdata_rep = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be        = Address[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{WriteData[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = WriteData;
            end
        endcase
        wr_en = is_store && !Reset && !(TRAP && mis);
        Stall = is_load && !Reset;
    end

    // single-port RAM: byte-enabled write or synchronous read
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
            end
        end else if (is_load) begin
            rdata_q <= mem[idx];
        end
    end

    // hold load controls across the wait cycle
    always_ff @(posedge Clk) begin
        if (is_load) begin
            ld_addr_q <= Address;
            ld_size_q <= MemSize;
            ld_sgn_q  <= MemSigned;
            ld_wreg_q <= WriteReg;
            ld_rw_q   <= RegWrite;
            ld_m2r_q  <= MemtoReg;
            ld_mis_q  <= mis;
        end
    end

    // next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        read_data_d = read_data_q;
        alu_d       = alu_q;
        wreg_d      = wreg_q;
        rw_d        = rw_q;
        m2r_d       = m2r_q;
        mis_d       = mis_q;
        unique case (state_q)
            IDLE: begin
                if (is_load) begin
                    state_d = LOAD_WAIT;
                end else if (InValid) begin
                    out_valid_d = 1'b1;
                    read_data_d = '0;
                    alu_d       = Address;
                    wreg_d      = WriteReg;
                    rw_d        = RegWrite && !(TRAP && mis);
                    m2r_d       = MemtoReg;
                    mis_d       = mis;
                end
            end
            LOAD_WAIT: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                read_data_d = (TRAP && ld_mis_q) ? 32'h0 :
                    extract(rdata_q, ld_size_q, ld_sgn_q, ld_addr_q[1:0]);
                alu_d       = ld_addr_q;
                wreg_d      = ld_wreg_q;
                rw_d        = ld_rw_q && !(TRAP && ld_mis_q);
                m2r_d       = ld_m2r_q;
                mis_d       = ld_mis_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            read_data_q <= '0;
            alu_q       <= '0;
            wreg_q      <= '0;
            rw_q        <= 1'b0;
            m2r_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            wreg_q      <= wreg_d;
            rw_q        <= rw_d;
            m2r_q       <= m2r_d;
            mis_q       <= mis_d;
        end
    end

    assign OutValid     = out_valid_q;
    assign ReadData     = read_data_q;
    assign OutAluResult = alu_q;
    assign OutWriteReg  = wreg_q;
    assign OutRegWrite  = rw_q;
    assign OutMemtoReg  = m2r_q;
    assign Misaligned   = mis_q;

endmodule
